// File: rtl/vc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// vc_rr_arbiter : round-robin drain of 4 source FIFOs into one destination FIFO
// Optional ARB_WORD_CNT_EN adds an 8-bit written-word counter.  Rev 1.0
// ============================================================================
module vc_rr_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_SRC    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init,
  input  logic [3:0]                    umbral_in,
  input  logic [NUM_SRC-1:0]            empty_in,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] data_in,
  input  logic                          almost_full_out,
  input  logic                          full_out,
  output logic [NUM_SRC-1:0]            rd_enable,
  output logic                          wr_enable_out,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [3:0]                    umbral_out,
  output logic [1:0]                    state,
  output logic                          idle
`ifdef ARB_WORD_CNT_EN
  ,
  output logic [7:0]                    word_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RESET  = 2'b00,
    S_INIT   = 2'b01,
    S_IDLE   = 2'b10,
    S_ACTIVE = 2'b11
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              last_grant_q;
  logic [3:0]              umbral_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   data_q;

  logic                    any_req;
  logic                    dst_busy;
  logic                    pop;
  logic                    found;
  logic [1:0]              grant_idx;
  logic [1:0]              cand;
  logic [DATA_WIDTH-1:0]   sel_word;

  assign any_req  = ~&empty_in;
  assign dst_busy = almost_full_out | full_out;

  // Search starts one past the last grant; the 2-bit index wraps 3->0 naturally.
  always_comb begin
    found     = 1'b0;
    grant_idx = last_grant_q;
    cand      = last_grant_q;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = last_grant_q + 2'(k);
      if (!found && !empty_in[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign pop      = (state_q == S_ACTIVE) && !dst_busy && found;
  assign sel_word = data_in[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    rd_enable = '0;
    if (pop) begin
      rd_enable[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   state_d = init ? S_INIT : S_IDLE;
      S_IDLE: begin
        if (init)                      state_d = S_INIT;
        else if (any_req && !dst_busy) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (init)                      state_d = S_INIT;
        else if (!any_req || dst_busy) state_d = S_IDLE;
      end
      default:  state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_RESET;
      last_grant_q <= 2'd3;
      umbral_q     <= '0;
      wr_q         <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        last_grant_q <= grant_idx;
      end
      if (state_q == S_INIT) begin
        umbral_q <= umbral_in;
      end
      // The popped word lands one cycle later regardless of the state we move to.
      wr_q   <= pop;
      data_q <= pop ? sel_word : '0;
    end
  end

  assign wr_enable_out = wr_q;
  assign data_out      = data_q;
  assign umbral_out    = umbral_q;
  assign state         = state_q;
  assign idle          = (state_q == S_IDLE) && !wr_q;

`ifdef ARB_WORD_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == S_INIT) begin
      cnt_q <= '0;
    end else if (wr_q) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign word_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vc_rr_arbiter : directed self-checking bench for vc_rr_arbiter.  Rev 1.0
// ============================================================================
module tb_vc_rr_arbiter;
  localparam int DW = 6;

  logic          clk;
  logic          reset;
  logic          init;
  logic [3:0]    umbral_in;
  logic [3:0]    empty_in;
  logic [4*DW-1:0] data_in;
  logic          almost_full_out;
  logic          full_out;
  logic [3:0]    rd_enable;
  logic          wr_enable_out;
  logic [DW-1:0] data_out;
  logic [3:0]    umbral_out;
  logic [1:0]    state;
  logic          idle;
`ifdef ARB_WORD_CNT_EN
  logic [7:0]    word_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [DW-1:0] D0 = 6'h0A;
  localparam logic [DW-1:0] D1 = 6'h15;
  localparam logic [DW-1:0] D2 = 6'h2C;
  localparam logic [DW-1:0] D3 = 6'h33;

  vc_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .umbral_in       (umbral_in),
    .empty_in        (empty_in),
    .data_in         (data_in),
    .almost_full_out (almost_full_out),
    .full_out        (full_out),
    .rd_enable       (rd_enable),
    .wr_enable_out   (wr_enable_out),
    .data_out        (data_out),
    .umbral_out      (umbral_out),
    .state           (state),
    .idle            (idle)
`ifdef ARB_WORD_CNT_EN
    ,
    .word_cnt        (word_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [DW-1:0] d);
    check({tag, "_wr"}, 32'(wr_enable_out), 32'(we));
    check({tag, "_data"}, 32'(data_out), 32'(d));
  endtask

  initial begin
    reset = 1'b0; init = 1'b0; umbral_in = 4'h0; empty_in = 4'hF;
    almost_full_out = 1'b0; full_out = 1'b0;
    data_in = {D3, D2, D1, D0};
    #1 reset = 1'b1;
    #2;
    check("rst_state", 32'(state), 32'h0);
    check("rst_umbral", 32'(umbral_out), 32'h0);
    chk_wr("rst", 1'b0, '0);
    check("rst_rd", 32'(rd_enable), 32'h0);
    check("rst_idle", 32'(idle), 32'h0);
`ifdef ARB_WORD_CNT_EN
    check("rst_cnt", 32'(word_cnt), 32'h0);
`endif
    cyc(); cyc();
    reset = 1'b0; init = 1'b1; umbral_in = 4'h3;
    #1;
    check("cfg_s0", 32'(state), 32'h0);
    cyc(); #1 check("cfg_s1", 32'(state), 32'h1);
    check("cfg_rd", 32'(rd_enable), 32'h0);
    cyc(); #1 check("cfg_s2", 32'(state), 32'h1);
    cyc(); #1 check("cfg_s3", 32'(state), 32'h1);
    check("cfg_umbral", 32'(umbral_out), 32'h3);
    init = 1'b0;
    cyc(); #1 check("cfg_s4", 32'(state), 32'h2);
    check("cfg_idle", 32'(idle), 32'h1);
    check("cfg_umbral_hold", 32'(umbral_out), 32'h3);

    // All sources non-empty: rotate 0,1,2,3,0 with one-cycle write latency
    empty_in = 4'h0;
    #1 check("rr_idle_rd", 32'(rd_enable), 32'h0);
    cyc(); #1 check("rr_state", 32'(state), 32'h3);
    check("rr_g0", 32'(rd_enable), 32'h1); chk_wr("rr_w0", 1'b0, '0);
    cyc(); #1 check("rr_g1", 32'(rd_enable), 32'h2); chk_wr("rr_w1", 1'b1, D0);
    cyc(); #1 check("rr_g2", 32'(rd_enable), 32'h4); chk_wr("rr_w2", 1'b1, D1);
    cyc(); #1 check("rr_g3", 32'(rd_enable), 32'h8); chk_wr("rr_w3", 1'b1, D2);
    cyc(); #1 check("rr_g4", 32'(rd_enable), 32'h1); chk_wr("rr_w4", 1'b1, D3);
    cyc(); #1 check("rr_g5", 32'(rd_enable), 32'h2); chk_wr("rr_w5", 1'b1, D0);

    // Only sources 1 and 3 non-empty; source 0 goes empty in the same cycle
    empty_in = 4'b0101;
    #1 check("alt_g0", 32'(rd_enable), 32'h2);
    cyc(); #1 check("alt_g1", 32'(rd_enable), 32'h8); chk_wr("alt_w1", 1'b1, D1);
    cyc(); #1 check("alt_g2", 32'(rd_enable), 32'h2); chk_wr("alt_w2", 1'b1, D3);
    cyc(); #1 check("alt_g3", 32'(rd_enable), 32'h8); chk_wr("alt_w3", 1'b1, D1);

    // almost_full blocks the pop combinationally; the in-flight word still lands
    almost_full_out = 1'b1;
    #1 check("af_rd", 32'(rd_enable), 32'h0); chk_wr("af_trail", 1'b1, D1);
    cyc(); #1 check("af_state", 32'(state), 32'h2); chk_wr("af_after", 1'b0, '0);
    check("af_idle", 32'(idle), 32'h1);
    cyc(); #1 check("af_hold", 32'(state), 32'h2);
    almost_full_out = 1'b0; full_out = 1'b1;
    cyc(); #1 check("full_hold", 32'(state), 32'h2);
    check("full_rd", 32'(rd_enable), 32'h0);
    full_out = 1'b0;
    cyc(); #1 check("resume_state", 32'(state), 32'h3);
    check("resume_rd", 32'(rd_enable), 32'h8);

    // init mid-ACTIVE: the pop of this cycle is still written, then no more pops
    init = 1'b1; umbral_in = 4'h9;
    #1 check("init_rd", 32'(rd_enable), 32'h8);
    cyc(); #1 check("init_state", 32'(state), 32'h1);
    check("init_rd_off", 32'(rd_enable), 32'h0); chk_wr("init_pend", 1'b1, D3);
    cyc(); #1 chk_wr("init_quiet", 1'b0, '0);
    check("init_umbral", 32'(umbral_out), 32'h9);
    init = 1'b0;
    cyc(); #1 check("init_exit", 32'(state), 32'h2);
    cyc(); #1 check("reenter", 32'(state), 32'h3);
    check("reenter_rd", 32'(rd_enable), 32'h2);
    cyc(); #1 chk_wr("reenter_w", 1'b1, D1);

    // Asynchronous reset between edges discards the pending write
    #1 reset = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'h0);
    check("arst_rd", 32'(rd_enable), 32'h0);
    chk_wr("arst", 1'b0, '0);
    check("arst_umbral", 32'(umbral_out), 32'h0);
    check("arst_idle", 32'(idle), 32'h0);
    #1 reset = 1'b0; empty_in = 4'h0;
    cyc(); #1 check("post_s1", 32'(state), 32'h1); chk_wr("post_nowr", 1'b0, '0);
    cyc(); #1 check("post_s2", 32'(state), 32'h2);
    cyc(); #1 check("post_s3", 32'(state), 32'h3);
    check("post_first_grant", 32'(rd_enable), 32'h1);
`ifdef ARB_WORD_CNT_EN
    check("cnt_start", 32'(word_cnt), 32'h0);
    cyc(); #1 check("cnt_0", 32'(word_cnt), 32'h0);
    cyc(); #1 check("cnt_1", 32'(word_cnt), 32'h1);
    repeat (255) cyc();
    #1 check("cnt_wrap", 32'(word_cnt), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
